// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcodes, default datapath width and the multiplier state encoding.
package alu_pkg;

    localparam logic [2:0] ALU_OP_ADD    = 3'b000;
    localparam logic [2:0] ALU_OP_SUB    = 3'b001;
    localparam int         DEFAULT_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXAM = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } state_t;

endpackage

// File: rtl/alu_mult_seq_if.sv
// Host request/response and external-ALU signals of the sequential Booth multiplier.
interface alu_mult_seq_if #(
    parameter int WIDTH = 16
);
    logic             req_valid;
    logic             req_ready;
    logic [WIDTH-1:0] req_a;
    logic [WIDTH-1:0] req_b;
    logic             resp_valid;
    logic             resp_ready;
    logic [WIDTH-1:0] resp_result;
    logic             resp_err;
    logic             alu_start;
    logic [2:0]       alu_op;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [WIDTH-1:0] alu_out;
    logic             alu_done;

    // environment side: host plus ALU
    modport master (
        output req_valid, req_a, req_b, resp_ready, alu_out, alu_done,
        input  req_ready, resp_valid, resp_result, resp_err,
               alu_start, alu_op, alu_a, alu_b
    );

    modport slave (
        input  req_valid, req_a, req_b, resp_ready, alu_out, alu_done,
        output req_ready, resp_valid, resp_result, resp_err,
               alu_start, alu_op, alu_a, alu_b
    );
endinterface

// File: rtl/alu_mult_seq.sv
// Radix-2 Booth signed multiplier driving an external add/sub ALU, one multiplier bit per step.
// Latency: WIDTH + 2*K cycles with a one-cycle ALU (K = ALU requests); per-request ALU timeout flags resp_err.
// Backpressure: one operation in flight, req_ready only in IDLE; result held until resp_ready.
module alu_mult_seq
    import alu_pkg::*;
#(
    parameter int WIDTH   = DEFAULT_WIDTH,
    parameter int TIMEOUT = 8
) (
    input  logic          clk,
    input  logic          rst,
    alu_mult_seq_if.slave bus
);
    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [IW-1:0] LAST_BIT = IW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] m, q, acc;
    logic             q_prev;
    logic [IW-1:0]    i;
    logic [CW-1:0]    cnt;
    logic             err;
    logic [1:0]       pair;
    logic             need_alu, last_bit, timeout;

    assign pair     = {q[i], q_prev};
    assign need_alu = pair[1] ^ pair[0];
    assign last_bit = (i == LAST_BIT);
    assign timeout  = (cnt == CNT_LAST) && !bus.alu_done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (bus.req_valid) state_nxt = EXAM;
            EXAM: begin
                if (need_alu)      state_nxt = WAIT;
                else if (last_bit) state_nxt = RESP;
            end
            WAIT: begin
                if (bus.alu_done)  state_nxt = last_bit ? RESP : EXAM;
                else if (timeout)  state_nxt = RESP;
            end
            RESP: if (bus.resp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready   = (state == IDLE);
        bus.resp_valid  = (state == RESP);
        bus.resp_result = (state == RESP) ? acc : '0;
        bus.resp_err    = (state == RESP) && err;
    end

    // Datapath; ALU operands only change when a new request is launched, so they hold through WAIT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m             <= '0;
            q             <= '0;
            acc           <= '0;
            q_prev        <= 1'b0;
            i             <= '0;
            cnt           <= '0;
            err           <= 1'b0;
            bus.alu_start <= 1'b0;
            bus.alu_op    <= ALU_OP_ADD;
            bus.alu_a     <= '0;
            bus.alu_b     <= '0;
        end else begin
            bus.alu_start <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        m      <= bus.req_a;
                        q      <= bus.req_b;
                        q_prev <= 1'b0;
                        acc    <= '0;
                        i      <= '0;
                        err    <= 1'b0;
                    end
                end
                EXAM: begin
                    if (need_alu) begin
                        bus.alu_start <= 1'b1;
                        bus.alu_op    <= pair[1] ? ALU_OP_SUB : ALU_OP_ADD;
                        bus.alu_a     <= acc;
                        bus.alu_b     <= m << i;
                        cnt           <= '0;
                    end else begin
                        q_prev <= q[i];
                        i      <= i + 1'b1;
                    end
                end
                WAIT: begin
                    if (bus.alu_done) begin
                        acc    <= bus.alu_out;
                        q_prev <= q[i];
                        i      <= i + 1'b1;
                    end else if (timeout) begin
                        acc <= '0;
                        err <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
